// File: rtl/laser_rx_array.sv
// rtl/laser_rx_array.sv - N-channel oversampling laser line receiver with per-channel holding and aligned release
// Optional even-parity bit between data and stop: define LASER_RX_PARITY_EN.
module laser_rx_array #(
    parameter int N_CH          = 2,
    parameter int DATA_W        = 8,
    parameter int OVERSAMPLE    = 8,
    parameter int ALIGN_TIMEOUT = 40
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_CH-1:0]        laser_in,
    input  logic                   simultaneous_mode,
    input  logic                   clear_err,
    output logic                   data_valid,
    output logic [N_CH-1:0]        ch_valid,
    output logic [N_CH*DATA_W-1:0] data_out,
    output logic [N_CH-1:0]        frame_err,
    output logic [N_CH-1:0]        overrun,
    output logic                   align_err,
    output logic [N_CH-1:0]        busy
);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WW  = $clog2(ALIGN_TIMEOUT + 1);
    localparam int MID = OVERSAMPLE / 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [N_CH-1:0]        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    state_t                 state_q [N_CH];
    state_t                 state_d [N_CH];
    logic [TW-1:0]          tick_q  [N_CH];
    logic [TW-1:0]          tick_d  [N_CH];
    logic [1:0]             votes_q [N_CH];
    logic [1:0]             votes_d [N_CH];
    logic [BW-1:0]          bits_q  [N_CH];
    logic [BW-1:0]          bits_d  [N_CH];
    logic [DATA_W-1:0]      shift_q [N_CH];
    logic [DATA_W-1:0]      shift_d [N_CH];
    logic [DATA_W-1:0]      hold_q  [N_CH];
    logic [DATA_W-1:0]      hold_d  [N_CH];
    logic [N_CH-1:0]        par_bad_q, par_bad_d, full_q, full_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic                   mode_q, mode_d;
    logic                   data_valid_q, data_valid_d, align_err_q, align_err_d;
    logic [N_CH-1:0]        ch_valid_q, ch_valid_d, frame_err_q, frame_err_d;
    logic [N_CH-1:0]        overrun_q, overrun_d, busy_q, busy_d;
    logic [N_CH*DATA_W-1:0] data_out_q, data_out_d;
    logic [N_CH-1:0]        vote_hit, bit_val, commit, bad_frame;

    // Majority over the three samples around mid-bit; the last vote may land on the decision tick.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            vote_hit[i] = sync2_q[i] && (tick_q[i] == TW'(MID - 1) || tick_q[i] == TW'(MID)
                                         || tick_q[i] == TW'(MID + 1));
            bit_val[i]  = (votes_q[i] + {1'b0, vote_hit[i]}) >= 2'd2;
        end
    end

    always_comb begin
        sync1_d   = laser_in;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        commit    = '0;
        bad_frame = '0;
        par_bad_d = par_bad_q;
        busy_d    = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            tick_d[i]  = tick_q[i];
            votes_d[i] = votes_q[i];
            bits_d[i]  = bits_q[i];
            shift_d[i] = shift_q[i];
            if (state_q[i] == S_IDLE) begin
                tick_d[i]  = '0;
                votes_d[i] = '0;
                if (sync2_q[i] && !prev_q[i])
                    state_d[i] = S_START;
            end else if (tick_q[i] != TW'(OVERSAMPLE - 1)) begin
                tick_d[i]  = tick_q[i] + TW'(1);
                votes_d[i] = votes_q[i] + {1'b0, vote_hit[i]};
            end else begin
                tick_d[i]  = '0;
                votes_d[i] = '0;
                case (state_q[i])
                    S_START: begin
                        state_d[i]   = bit_val[i] ? S_DATA : S_IDLE;
                        bits_d[i]    = '0;
                        par_bad_d[i] = 1'b0;
                    end
                    S_DATA: begin
                        shift_d[i] = {bit_val[i], shift_q[i][DATA_W-1:1]};
                        bits_d[i]  = bits_q[i] + BW'(1);
                        if (bits_q[i] == BW'(DATA_W - 1))
`ifdef LASER_RX_PARITY_EN
                            state_d[i] = S_PARITY;
`else
                            state_d[i] = S_STOP;
`endif
                    end
                    S_PARITY: begin
                        par_bad_d[i] = bit_val[i] != (^shift_q[i]);
                        state_d[i]   = S_STOP;
                    end
                    S_STOP: begin
                        state_d[i] = S_IDLE;
                        if (bit_val[i] || par_bad_q[i])
                            bad_frame[i] = 1'b1;
                        else
                            commit[i] = 1'b1;
                    end
                    default: state_d[i] = S_IDLE;
                endcase
            end
            busy_d[i] = state_d[i] != S_IDLE;
        end
    end

    // Release is resolved before commits so a byte can land in a register emptied this cycle.
    always_comb begin
        full_d       = full_q;
        hold_d       = hold_q;
        wait_d       = wait_q;
        mode_d       = simultaneous_mode;
        data_valid_d = 1'b0;
        align_err_d  = 1'b0;
        ch_valid_d   = '0;
        data_out_d   = data_out_q;
        if (simultaneous_mode != mode_q) begin
            full_d = '0;
            wait_d = '0;
        end else if (!simultaneous_mode) begin
            wait_d = '0;
            if (|full_q) begin
                data_valid_d = 1'b1;
                ch_valid_d   = full_q;
                full_d       = '0;
            end
        end else if (&full_q) begin
            data_valid_d = 1'b1;
            ch_valid_d   = '1;
            full_d       = '0;
            wait_d       = '0;
        end else if (|full_q) begin
            if (wait_q == WW'(ALIGN_TIMEOUT - 1)) begin
                full_d      = '0;
                align_err_d = 1'b1;
                wait_d      = '0;
            end else begin
                wait_d = wait_q + WW'(1);
            end
        end else begin
            wait_d = '0;
        end
        overrun_d   = clear_err ? '0 : overrun_q;
        frame_err_d = (clear_err ? '0 : frame_err_q) | bad_frame;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_valid_d[i])
                data_out_d[i*DATA_W +: DATA_W] = hold_q[i];
            if (commit[i]) begin
                if (full_d[i]) begin
                    overrun_d[i] = 1'b1;
                end else begin
                    hold_d[i] = shift_q[i];
                    full_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            state_q      <= '{default: S_IDLE};
            tick_q       <= '{default: '0};
            votes_q      <= '{default: '0};
            bits_q       <= '{default: '0};
            shift_q      <= '{default: '0};
            hold_q       <= '{default: '0};
            par_bad_q    <= '0;
            full_q       <= '0;
            wait_q       <= '0;
            mode_q       <= 1'b0;
            data_valid_q <= 1'b0;
            align_err_q  <= 1'b0;
            ch_valid_q   <= '0;
            frame_err_q  <= '0;
            overrun_q    <= '0;
            busy_q       <= '0;
            data_out_q   <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            tick_q       <= tick_d;
            votes_q      <= votes_d;
            bits_q       <= bits_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            par_bad_q    <= par_bad_d;
            full_q       <= full_d;
            wait_q       <= wait_d;
            mode_q       <= mode_d;
            data_valid_q <= data_valid_d;
            align_err_q  <= align_err_d;
            ch_valid_q   <= ch_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            data_out_q   <= data_out_d;
        end
    end

    assign data_valid = data_valid_q;
    assign ch_valid   = ch_valid_q;
    assign data_out   = data_out_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign align_err  = align_err_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_laser_rx_array.sv
// tb/tb_laser_rx_array.sv - scoreboard bench for laser_rx_array with random frames and a timing model
module tb_laser_rx_array;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int OS = 8;
    localparam int AT = 100;
`ifdef LASER_RX_PARITY_EN
    localparam int F = DW + 3;
`else
    localparam int F = DW + 2;
`endif
    // First edge sampling the start bit to the edge that commits the byte.
    localparam int LAT = 2 + F * OS;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      laser_in = '0;
    logic              simultaneous_mode = 1'b0;
    logic              clear_err = 1'b0;
    logic              data_valid, align_err;
    logic [N-1:0]      ch_valid, frame_err, overrun, busy;
    logic [N*DW-1:0]   data_out;

    laser_rx_array #(.N_CH(N), .DATA_W(DW), .OVERSAMPLE(OS), .ALIGN_TIMEOUT(AT)) dut (
        .clock(clock), .reset(reset), .laser_in(laser_in),
        .simultaneous_mode(simultaneous_mode), .clear_err(clear_err),
        .data_valid(data_valid), .ch_valid(ch_valid), .data_out(data_out),
        .frame_err(frame_err), .overrun(overrun), .align_err(align_err), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int            at;
        bit            is_align;
        logic [N-1:0]  chv;
        logic [N*DW-1:0] data;
    } exp_t;
    exp_t sbq[$];
    exp_t e;
    bit   ok;

    logic [DW-1:0] tx_byte [N];
    int            tx_off  [N];
    logic [N-1:0]  tx_bad;
    logic [N-1:0]  rmask, exp_fe;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every pulse the DUT presents must match the oldest predicted event, cycle included.
    always @(negedge clock) begin
        if (!reset && (data_valid || align_err)) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cycle=%0d dv=%b ae=%b chv=%b data=%h",
                         cyc, data_valid, align_err, ch_valid, data_out);
            end else begin
                e  = sbq.pop_front();
                ok = (cyc == e.at) && (align_err == e.is_align) && (data_valid == !e.is_align);
                if (!e.is_align) begin
                    ok = ok && (ch_valid == e.chv);
                    for (int l = 0; l < N; l++)
                        if (e.chv[l] && data_out[l*DW +: DW] !== e.data[l*DW +: DW])
                            ok = 1'b0;
                end
                if (!ok) begin
                    errors++;
                    $display("FAIL scoreboard got cycle=%0d dv=%b ae=%b chv=%b data=%h expected cycle=%0d ae=%b chv=%b data=%h",
                             cyc, data_valid, align_err, ch_valid, data_out, e.at, e.is_align, e.chv, e.data);
                end
            end
        end
    end

    function automatic logic fbit(input logic [DW-1:0] b, input int k, input logic bad_stop);
        logic [DW-1:0] s;
        if (k == 0) return 1'b1;
        if (k <= DW) begin
            s = b >> (k - 1);
            return s[0];
        end
`ifdef LASER_RX_PARITY_EN
        if (k == DW + 1) return ^b;
`endif
        return bad_stop;
    endfunction

    function automatic void push_data(input int at, input logic [N-1:0] chv);
        exp_t x;
        x.at = at;
        x.is_align = 1'b0;
        x.chv = chv;
        x.data = '0;
        for (int l = 0; l < N; l++) x.data[l*DW +: DW] = tx_byte[l];
        sbq.push_back(x);
    endfunction

    function automatic void push_align(input int at);
        exp_t x;
        x.at = at;
        x.is_align = 1'b1;
        x.chv = '0;
        x.data = '0;
        sbq.push_back(x);
    endfunction

    // Drives each masked channel's frame starting tx_off cycles in; line idles low otherwise.
    task automatic play(input logic [N-1:0] mask, input int ncyc);
        for (int t = 0; t < ncyc; t++) begin
            for (int l = 0; l < N; l++) begin
                int r;
                r = t - tx_off[l];
                laser_in[l] = mask[l] && (r >= 0) && (r < F * OS) && fbit(tx_byte[l], r / OS, tx_bad[l]);
            end
            @(negedge clock);
        end
        laser_in = '0;
    endtask

    // Predicts releases from commit times: independent mode pulses the cycle after each commit cycle,
    // simultaneous mode pulses once after the last commit, or times out from the first.
    task automatic txn(input logic [N-1:0] mask, input int extra);
        int c [N];
        int minc, maxc, maxoff;
        logic [N-1:0] good, m;
        good = mask & ~tx_bad;
        minc = 32'h7fffffff;
        maxc = 0;
        maxoff = 0;
        for (int l = 0; l < N; l++) begin
            c[l] = cyc + tx_off[l] + 1 + LAT;
            if (good[l] && c[l] < minc) minc = c[l];
            if (good[l] && c[l] > maxc) maxc = c[l];
            if (mask[l] && tx_off[l] > maxoff) maxoff = tx_off[l];
        end
        if (good != '0) begin
            if (!simultaneous_mode) begin
                for (int t = minc; t <= maxc; t++) begin
                    m = '0;
                    for (int l = 0; l < N; l++)
                        if (good[l] && c[l] == t) m[l] = 1'b1;
                    if (m != '0) push_data(t + 1, m);
                end
            end else if (good == '1) begin
                push_data(maxc + 1, '1);
            end else begin
                push_align(minc + AT);
            end
        end
        play(mask, maxoff + F * OS + 10 + extra);
    endtask

    task automatic set_mode(input logic m);
        simultaneous_mode = m;
        repeat (2) @(negedge clock);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_valid"}, 64'(data_valid), 64'd0);
        check({tag, "_ch_valid"},   64'(ch_valid),   64'd0);
        check({tag, "_data_out"},   64'(data_out),   64'd0);
        check({tag, "_frame_err"},  64'(frame_err),  64'd0);
        check({tag, "_overrun"},    64'(overrun),    64'd0);
        check({tag, "_align_err"},  64'(align_err),  64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
    endtask

    initial begin
        for (int l = 0; l < N; l++) begin
            tx_byte[l] = '0;
            tx_off[l]  = 0;
        end
        tx_bad = '0;
        exp_fe = '0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Independent single byte: pulse 83 cycles after the first sampling edge.
        tx_byte[0] = 8'hA5;
        txn(2'b01, 0);
        check("indep_frame_err", 64'(frame_err), 64'd0);

        // Simultaneous: staggered channels combine into one aligned word.
        set_mode(1'b1);
        tx_byte[0] = 8'h3C; tx_byte[1] = 8'hC3; tx_off[1] = 20;
        txn(2'b11, 0);
        tx_off[1] = 0;

        // Simultaneous, only ch1 sends: timeout flush with align_err.
        tx_byte[1] = 8'h96;
        txn(2'b10, AT + 10);

        for (int k = 0; k < 10; k++) begin
            for (int l = 0; l < N; l++) begin
                tx_byte[l] = DW'($urandom);
                tx_off[l]  = int'($urandom_range(0, 30));
            end
            txn('1, 0);
        end
        for (int l = 0; l < N; l++) tx_off[l] = 0;

        // Overrun: a second ch0 byte completes while the first is still waiting for alignment.
        tx_byte[0] = 8'h11;
        push_align(cyc + 1 + LAT + AT);
        play(2'b01, F * OS + OS);
        tx_byte[0] = 8'h22;
        play(2'b01, F * OS + AT + 10);
        check("overrun_set", 64'(overrun), 64'd1);
        check("overrun_no_frame_err", 64'(frame_err), 64'd0);
        pulse_clear();
        check("overrun_cleared", 64'(overrun), 64'd0);

        // Mode change while a partial word is held: silent flush.
        tx_byte[0] = 8'h77;
        play(2'b01, F * OS + 10);
        set_mode(1'b0);
        repeat (AT + 20) @(negedge clock);
        check("mode_flush_quiet", 64'(sbq.size()), 64'd0);
        check("mode_flush_no_err", 64'({frame_err, overrun}), 64'd0);
        tx_byte[0] = 8'h4D;
        txn(2'b01, 0);

        // Bad stop bit: sticky frame_err until cleared, byte dropped.
        tx_byte[0] = 8'hE7;
        tx_bad = 2'b01;
        txn(2'b01, 0);
        tx_bad = '0;
        repeat (5) @(negedge clock);
        check("bad_stop_frame_err", 64'(frame_err), 64'd1);
        pulse_clear();
        check("frame_err_cleared", 64'(frame_err), 64'd0);

        // One-tick glitch: start rejected after one bit time, no error.
        laser_in[0] = 1'b1;
        @(negedge clock);
        laser_in[0] = 1'b0;
        repeat (5) @(negedge clock);
        check("glitch_busy_high", 64'(busy), 64'd1);
        repeat (7) @(negedge clock);
        check("glitch_busy_low", 64'(busy), 64'd0);
        check("glitch_no_frame_err", 64'(frame_err), 64'd0);

        for (int k = 0; k < 20; k++) begin
            for (int l = 0; l < N; l++) begin
                tx_byte[l] = DW'($urandom);
                tx_off[l]  = int'($urandom_range(0, 3));
                tx_bad[l]  = ($urandom_range(0, 4) == 0);
            end
            rmask = N'($urandom_range(1, (1 << N) - 1));
            txn(rmask, 0);
            exp_fe = exp_fe | (rmask & tx_bad);
            check("random_frame_err", 64'(frame_err), 64'(exp_fe));
            if ($urandom_range(0, 2) == 0) begin
                pulse_clear();
                exp_fe = '0;
            end
        end
        tx_bad = '0;
        for (int l = 0; l < N; l++) tx_off[l] = 0;

        // Reset mid-DATA discards the frame; the next frame is clean.
        tx_byte[0] = 8'hFF;
        play(2'b01, 40);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tx_byte[0] = 8'h5A;
        txn(2'b01, 0);

        repeat (20) @(negedge clock);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
